div_iter: RTL

- Iterative 32-bit radix-2 restoring divider.
- Acts as the responder for the EX stage's divide request (div_opdata1/2, div_start, signed_div) and returns the 64-bit result with a ready flag.
- Serves MIPS DIV/DIVU. The result is formatted {remainder, quotient} so EX can write it directly to HI/LO.
- EX holds start_i high and stalls the pipeline until ready_o is seen.

---
 rtl/div_iter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU.
// Takes WIDTH iterations and returns {remainder, quotient} with a ready flag.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    // Handshake: the requester holds start_i high (operands valid on the
    // accepting edge only) until it sees ready_o; ready_o and result_o stay
    // put until start_i drops, then both clear on the following edge.

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_FREE = 2'd0,
        ST_DBZ  = 2'd1,
        ST_ON   = 2'd2,
        ST_END  = 2'd3
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [2*WIDTH:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             sign_mode;
    logic             neg1;
    logic             neg2;

    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;

    always_comb begin
        mag1 = opdata1_i;
        mag2 = opdata2_i;
        if (signed_div_i && opdata1_i[WIDTH-1]) mag1 = -opdata1_i;
        if (signed_div_i && opdata2_i[WIDTH-1]) mag2 = -opdata2_i;

        // Extra top bit of the trial is the borrow: set means "does not fit".
        trial = {1'b0, dividend[2*WIDTH-1:WIDTH]} - {1'b0, divisor};

        quo = dividend[WIDTH-1:0];
        rem = dividend[2*WIDTH:WIDTH+1];
        if (sign_mode && (neg1 ^ neg2)) quo = -dividend[WIDTH-1:0];
        if (sign_mode && neg1)          rem = -dividend[2*WIDTH:WIDTH+1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_FREE;
            cnt       <= '0;
            result_o  <= '0;
            ready_o   <= 1'b0;
            dividend  <= '0;
            divisor   <= '0;
            sign_mode <= 1'b0;
            neg1      <= 1'b0;
            neg2      <= 1'b0;
        end else begin
            case (state)
                ST_FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            state <= ST_DBZ;
                        end else begin
                            state     <= ST_ON;
                            cnt       <= '0;
                            dividend  <= {{WIDTH{1'b0}}, mag1, 1'b0};
                            divisor   <= mag2;
                            sign_mode <= signed_div_i;
                            neg1      <= opdata1_i[WIDTH-1];
                            neg2      <= opdata2_i[WIDTH-1];
                        end
                    end
                end
                ST_DBZ: begin
                    state    <= ST_END;
                    result_o <= '0;
                    ready_o  <= 1'b1;
                end
                ST_ON: begin
                    if (annul_i) begin
                        state   <= ST_FREE;
                        cnt     <= '0;
                        ready_o <= 1'b0;
                    end else if (cnt != CW'(WIDTH)) begin
                        if (trial[WIDTH])
                            dividend <= {dividend[2*WIDTH-1:0], 1'b0};
                        else
                            dividend <= {trial[WIDTH-1:0], dividend[WIDTH-1:0], 1'b1};
                        cnt <= cnt + 1'b1;
                    end else begin
                        state    <= ST_END;
                        result_o <= {rem, quo};
                        ready_o  <= 1'b1;
                    end
                end
                ST_END: begin
                    if (!start_i) begin
                        state    <= ST_FREE;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end
                end
                default: state <= ST_FREE;
            endcase
        end
    end

endmodule
